cpu_run_controller: RTL
=======================

// Module: cpu_run_controller
// PURPOSE
//  Run/halt/single-step sequencer for the CPU core. Generates the one-cycle cpu_en
//  pulse that advances the CPU by one instruction.
//  Sits between the board inputs (debounced step button, run switch) and the CPU core.
//  Also counts retired instructions and, optionally, halts on a PC breakpoint.
// PARAMETERS
//  PRESCALE  25_000_000  clk cycles between cpu_en pulses in RUN; must be >= 1
//  CNT_W     25          width of the prescale counter; must hold PRESCALE-1
// PORTS
//  clk       in   1   system clock; single clock domain
//  reset_n   in   1   synchronous, active-low reset
//  run_sw    in   1   level; 1 = free-run requested
//  step_btn  in   1   debounced, active-high; each rising edge = one step
//  cnt_clr   in   1   synchronous clear of inst_cnt
//  pc        in   32  current CPU program counter
//  bp_adrs   in   32  breakpoint address
//  bp_valid  in   1   breakpoint armed
//  cpu_en    out  1   registered; 1-cycle pulse, CPU executes one instruction
//  running   out  1   registered; 1 when state==RUN
//  bp_hit    out  1   registered; 1 when state==BRK
//  inst_cnt  out  32  registered; count of cpu_en pulses issued
// BEHAVIOUR
//  Reset (reset_n==0 at an edge): state=HALT, div_cnt=0, cpu_en=0, inst_cnt=0,
//   bp_hit=0, running=0, step_prev=1. A button held through reset does not step.
//  Step edge: step_btn==1 && step_prev==0, sampled at an edge; step_prev<=step_btn every cycle.
//  FSM states HALT, RUN, BRK. All outputs register at the deciding edge:
//  - HALT:
//    - step edge: cpu_en<=1 for exactly one cycle, then state<=(run_sw ? RUN : HALT).
//    - else if run_sw==1: state<=RUN, div_cnt<=0.
//  - RUN:
//    - run_sw==0: state<=HALT, div_cnt<=0, no pulse (halt beats a simultaneous tick).
//    - Step edges are ignored.
//    - Otherwise div_cnt increments. At div_cnt==PRESCALE-1 it wraps to 0 (tick).
//      On a tick, cpu_en<=1 (unless the breakpoint matches).
//    - First pulse comes PRESCALE cycles after entering RUN. Pulse period is exactly PRESCALE.
//  - BRK:
//    - step edge: cpu_en<=1 with no breakpoint compare, bp_hit<=0, div_cnt<=0,
//      state<=(run_sw ? RUN : HALT). A step beats a simultaneous run_sw==0.
//    - else run_sw==0: state<=HALT, bp_hit<=0.
//    - else hold.
//  cpu_en is never high on two consecutive cycles when PRESCALE>=2.
//  pc is sampled only when cpu_en==0 and is therefore stable.
//  inst_cnt: +1 on each cycle cpu_en==1; wraps FFFF_FFFF->0. cnt_clr has priority and sets
//   inst_cnt<=0, even if cpu_en==1 in the same cycle.
//  running and bp_hit are decoded from the next-state value and registered.
// CONFIGURATION
//  CPU_BREAKPOINT_EN defined:
//   - A RUN tick with bp_valid && pc==bp_adrs suppresses cpu_en and sets state<=BRK, bp_hit<=1.
//  Undefined:
//   - BRK is unreachable; bp_adrs and bp_valid are ignored; bp_hit is tied to 0.
//   - Port list is identical in both builds.
// STRUCTURE
//  defines.v: state encodings `CTL_HALT 2'd0, `CTL_RUN 2'd1, `CTL_BRK 2'd2.
//  Sub-module tick_gen (#PRESCALE, CNT_W):
//   - Inputs: clk, reset_n, clear (synchronous, zeroes div_cnt).
//   - Output: tick, combinational (div_cnt==PRESCALE-1).
//   - The FSM qualifies tick with state and run_sw.
// TESTING  (bench uses PRESCALE=4)
//  1. Reset with step_btn=1 held, then release the button -> no cpu_en; state HALT; inst_cnt=0.
//  2. HALT, single step_btn rise -> cpu_en high exactly 1 cycle (at the next edge); inst_cnt=1;
//     holding the button gives no further pulse.
//  3. run_sw=1 for 20 cycles -> pulses on cycles 5,9,13,17 after the sample edge
//     (period 4); running=1; inst_cnt=4.
//     Drop run_sw on the edge where div_cnt==3 -> no pulse; HALT.
//  4. CPU_BREAKPOINT_EN, bp_valid=1, bp_adrs=0x10, pc=0x10, run -> first tick gives cpu_en=0,
//     bp_hit=1. step rise -> one pulse, bp_hit=0, back to RUN.
//  5. cnt_clr=1 in the same cycle as a cpu_en pulse with inst_cnt=0xFFFF_FFFF -> inst_cnt=0.
//     Next pulse -> inst_cnt=1.
//  6. Macro undefined, same stimulus as 4 -> no BRK; pulses continue every 4 cycles; bp_hit=0.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_controller_pkg
//   Shared types and widths for the CPU run/halt/single-step sequencer.
//   State encodings: HALT=0, RUN=1, BRK=2.
// ---------------------------------------------------------------------------
package cpu_run_controller_pkg;

  typedef enum logic [1:0] {
    CTL_HALT = 2'd0,
    CTL_RUN  = 2'd1,
    CTL_BRK  = 2'd2
  } ctl_state_e;

  localparam int INST_CNT_W = 32;
  localparam int PC_W       = 32;

endpackage

// File: rtl/cpu_run_controller_tick_gen.sv
// ---------------------------------------------------------------------------
// cpu_run_controller_tick_gen
//   Prescale divider for free-run mode. div_cnt counts 0..PRESCALE-1 and wraps.
//   tick is combinational and high while div_cnt==PRESCALE-1.
// Ports:
//   clk      in  system clock
//   reset_n  in  synchronous active-low reset (zeroes div_cnt)
//   clear    in  synchronous clear (zeroes div_cnt)
//   tick     out combinational, div_cnt==PRESCALE-1
// ---------------------------------------------------------------------------
module cpu_run_controller_tick_gen #(
  parameter int PRESCALE = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//   Run/halt/single-step sequencer for the CPU core. Produces a one-cycle
//   cpu_en pulse per instruction, either from a step button edge or from a
//   prescaled free-run tick, and counts issued pulses.
//   Optional feature macro: CPU_BREAKPOINT_EN -- a free-run tick whose pc
//   matches an armed breakpoint is swallowed and the sequencer parks in BRK.
//   Without the macro BRK is unreachable and bp_hit is tied low; the port
//   list is the same in both builds.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   run_sw    in   level, 1 = free-run requested
//   step_btn  in   debounced, each rising edge = one step
//   cnt_clr   in   synchronous clear of inst_cnt (beats an increment)
//   pc        in   current CPU program counter
//   bp_adrs   in   breakpoint address
//   bp_valid  in   breakpoint armed
//   cpu_en    out  registered 1-cycle enable pulse
//   running   out  registered, state==RUN
//   bp_hit    out  registered, state==BRK
//   inst_cnt  out  registered count of cpu_en pulses
// ---------------------------------------------------------------------------
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int PRESCALE = 25_000_000,
  parameter int CNT_W    = 25
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run_sw,
  input  logic                  step_btn,
  input  logic                  cnt_clr,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_adrs,
  input  logic                  bp_valid,
  output logic                  cpu_en,
  output logic                  running,
  output logic                  bp_hit,
  output logic [INST_CNT_W-1:0] inst_cnt
);

  ctl_state_e state;
  ctl_state_e next_state;
  logic       next_en;
  logic       step_prev;
  logic       step_edge;
  logic       tick;
  logic       div_clear;
  logic       bp_match;

  // step_prev resets to 1 so a button held through reset is not an edge.
  assign step_edge = step_btn && !step_prev;

  // Divider only runs while we stay in RUN; any other cycle restarts it so
  // the first pulse after entering RUN lands exactly PRESCALE cycles later.
  assign div_clear = !((state == CTL_RUN) && run_sw);

  cpu_run_controller_tick_gen #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (div_clear),
    .tick    (tick)
  );

`ifdef CPU_BREAKPOINT_EN
  // pc is only looked at on a RUN tick, when cpu_en is low and pc is stable.
  assign bp_match = bp_valid && (pc == bp_adrs);
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc, bp_adrs, bp_valid};
`endif

  always_comb begin
    next_state = state;
    next_en    = 1'b0;
    case (state)
      CTL_HALT: begin
        if (step_edge) begin
          next_en    = 1'b1;
          next_state = run_sw ? CTL_RUN : CTL_HALT;
        end else if (run_sw) begin
          next_state = CTL_RUN;
        end
      end
      CTL_RUN: begin
        // Dropping run_sw wins over a tick on the same edge.
        if (!run_sw) begin
          next_state = CTL_HALT;
        end else if (tick) begin
          if (bp_match) next_state = CTL_BRK;
          else          next_en    = 1'b1;
        end
      end
      CTL_BRK: begin
        // A step leaves BRK without re-checking the breakpoint.
        if (step_edge) begin
          next_en    = 1'b1;
          next_state = run_sw ? CTL_RUN : CTL_HALT;
        end else if (!run_sw) begin
          next_state = CTL_HALT;
        end
      end
      default: next_state = CTL_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= CTL_HALT;
      cpu_en    <= 1'b0;
      running   <= 1'b0;
      step_prev <= 1'b1;
      inst_cnt  <= '0;
    end else begin
      state     <= next_state;
      cpu_en    <= next_en;
      running   <= (next_state == CTL_RUN);
      step_prev <= step_btn;
      if (cnt_clr)     inst_cnt <= '0;
      else if (cpu_en) inst_cnt <= inst_cnt + INST_CNT_W'(1);
    end
  end

`ifdef CPU_BREAKPOINT_EN
  logic bp_hit_q;

  always_ff @(posedge clk) begin
    if (!reset_n) bp_hit_q <= 1'b0;
    else          bp_hit_q <= (next_state == CTL_BRK);
  end

  assign bp_hit = bp_hit_q;
`else
  assign bp_hit = 1'b0;
`endif

endmodule
